// File: rtl/exu_mem_access_if.sv
// Cache-side bus of the load/store execution unit.
// The operation encoding shared with the issue logic lives alongside it.
package exu_mem_access_pkg;
    typedef enum logic [3:0] {
        LB, LBU, LH, LHU, LW,
        SB, SH, SW,
        ADD, SUB, AND_OP, OR_OP, NOP
    } instr_name_e;
endpackage

interface exu_mem_access_if #(
    parameter int XLEN = 32
);
    logic              cache_req;
    logic              cache_we;
    logic [XLEN-1:0]   cache_address;
    logic [XLEN-1:0]   cache_wdata;
    logic [XLEN/8-1:0] cache_be;
    logic              cache_ack;
    logic [XLEN-1:0]   cache_rdata;

    modport master (
        output cache_req, cache_we, cache_address,
        output cache_wdata, cache_be,
        input  cache_ack, cache_rdata
    );

    modport slave (
        input  cache_req, cache_we, cache_address,
        input  cache_wdata, cache_be,
        output cache_ack, cache_rdata
    );
endinterface

// File: rtl/exu_mem_access.sv
// Serial load/store unit: one operation in flight,
// alignment check, lane steering and load extension.
module exu_mem_access
    import exu_mem_access_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  instr_name_e          instr_name,
    input  logic [XLEN-1:0]      data_1,
    input  logic [XLEN-1:0]      data_2,
    input  logic [XLEN-1:0]      immediate,
    input  logic [TAG_WIDTH-1:0] tag,
    input  logic                 flush,
    exu_mem_access_if.master     cache,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [XLEN-1:0]      result,
    output logic [TAG_WIDTH-1:0] result_tag,
    output logic                 fault
);
    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    state_e              state;
    logic                kill;
    logic                sgn_q;
    logic [1:0]          sz_q;
    logic [LANE_W-1:0]   lane_q;
    logic [XLEN-1:0]     data2_q;

    logic                is_ld;
    logic                is_st;
    logic                sgn;
    logic [1:0]          sz;
    logic [XLEN-1:0]     ea;
    logic [LANE_W-1:0]   lane;
    logic                mis;
    logic [NB-1:0]       mask;
    logic [XLEN-1:0]     wrep;
    logic [XLEN-1:0]     sh;
    logic [XLEN-1:0]     ld_val;

    assign in_ready = (state == S_IDLE) && !reset;
    assign ea       = data_1 + immediate;
    assign lane     = ea[LANE_W-1:0];
    assign mis      = (sz == 2'd1 && ea[0]) ||
                      (sz == 2'd2 && ea[1:0] != 2'b00);

    // Decode the offered operation into direction, size and signedness.
    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        sgn   = 1'b0;
        sz    = 2'd0;
        unique case (instr_name)
            LB:      begin is_ld = 1'b1; sgn = 1'b1; end
            LBU:     begin is_ld = 1'b1; end
            LH:      begin is_ld = 1'b1; sgn = 1'b1; sz = 2'd1; end
            LHU:     begin is_ld = 1'b1; sz = 2'd1; end
            LW:      begin is_ld = 1'b1; sgn = 1'b1; sz = 2'd2; end
            SB:      begin is_st = 1'b1; end
            SH:      begin is_st = 1'b1; sz = 2'd1; end
            SW:      begin is_st = 1'b1; sz = 2'd2; end
            default: ;
        endcase
    end

    // Byte-enable footprint and replicated store data; replication puts
    // the store bytes in every lane so the byte enables pick the right one.
    always_comb begin
        unique case (sz)
            2'd0: begin
                mask = NB'(1);
                wrep = {NB{data_2[7:0]}};
            end
            2'd1: begin
                mask = NB'(3);
                wrep = {(XLEN/16){data_2[15:0]}};
            end
            default: begin
                mask = NB'(15);
                wrep = {(XLEN/32){data_2[31:0]}};
            end
        endcase
    end

    // Bring the addressed lane of the read word down to bit 0 and extend.
    always_comb begin
        sh = cache.cache_rdata >> {lane_q, 3'b000};
        unique case (sz_q)
            2'd0:    ld_val = sgn_q ? XLEN'($signed(sh[7:0]))
                                    : XLEN'(sh[7:0]);
            2'd1:    ld_val = sgn_q ? XLEN'($signed(sh[15:0]))
                                    : XLEN'(sh[15:0]);
            default: ld_val = sgn_q ? XLEN'($signed(sh[31:0]))
                                    : XLEN'(sh[31:0]);
        endcase
    end

    // Control FSM with registered cache and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= S_IDLE;
            kill                <= 1'b0;
            sgn_q               <= 1'b0;
            sz_q                <= 2'd0;
            lane_q              <= '0;
            data2_q             <= '0;
            cache.cache_req     <= 1'b0;
            cache.cache_we      <= 1'b0;
            cache.cache_address <= '0;
            cache.cache_wdata   <= '0;
            cache.cache_be      <= '0;
            result_valid        <= 1'b0;
            result              <= '0;
            result_tag          <= '0;
            fault               <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        result_tag <= tag;
                        if (!is_ld && !is_st) begin
                            state        <= S_DONE;
                            result_valid <= 1'b1;
                            result       <= '0;
                            fault        <= 1'b0;
                        end else if (mis) begin
                            state        <= S_DONE;
                            result_valid <= 1'b1;
                            result       <= ea;
                            fault        <= 1'b1;
                        end else begin
                            state               <= S_REQ;
                            sgn_q               <= sgn;
                            sz_q                <= sz;
                            lane_q              <= lane;
                            data2_q             <= data_2;
                            cache.cache_req     <= 1'b1;
                            cache.cache_we      <= is_st;
                            cache.cache_address <=
                                {ea[XLEN-1:LANE_W], {LANE_W{1'b0}}};
                            cache.cache_be      <= mask << lane;
                            cache.cache_wdata   <= wrep;
                        end
                    end
                end
                S_REQ: begin
                    if (flush) kill <= 1'b1;
                    if (cache.cache_ack) begin
                        cache.cache_req <= 1'b0;
                        kill            <= 1'b0;
                        if (kill || flush) begin
                            state <= S_IDLE;
                        end else begin
                            state        <= S_DONE;
                            result_valid <= 1'b1;
                            fault        <= 1'b0;
                            result       <= cache.cache_we ? data2_q
                                                           : ld_val;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || result_ready) begin
                        state        <= S_IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_mem_access.sv
// Bench for exu_mem_access: directed scenarios plus randomized
// operations checked against an arithmetic model of load/store behaviour.
module tb_exu_mem_access;
    import exu_mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    instr_name_e instr_name;
    logic [31:0] data_1, data_2, immediate;
    logic [5:0]  tag;
    logic        flush;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic [5:0]  result_tag;
    logic        fault;

    int n_total = 0;
    int n_pass  = 0;

    exu_mem_access_if #(.XLEN(32)) cif ();

    exu_mem_access #(.XLEN(32), .TAG_WIDTH(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr_name   (instr_name),
        .data_1       (data_1),
        .data_2       (data_2),
        .immediate    (immediate),
        .tag          (tag),
        .flush        (flush),
        .cache        (cif),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_tag   (result_tag),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    endtask

    function automatic int size_of(input instr_name_e op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    task automatic check_zero_outputs(input string nm);
        check({nm, "_req"},   cif.cache_req, 0);
        check({nm, "_we"},    cif.cache_we, 0);
        check({nm, "_be"},    cif.cache_be, 0);
        check({nm, "_addr"},  cif.cache_address, 0);
        check({nm, "_wdata"}, cif.cache_wdata, 0);
        check({nm, "_rv"},    result_valid, 0);
        check({nm, "_res"},   result, 0);
        check({nm, "_tag"},   result_tag, 0);
        check({nm, "_fault"}, fault, 0);
    endtask

    task automatic offer(input instr_name_e op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm,
                         input logic [5:0] tg);
        in_valid   = 1'b1;
        instr_name = op;
        data_1     = d1;
        data_2     = d2;
        immediate  = imm;
        tag        = tg;
    endtask

    // One full operation: offer, serve the cache, hold the result, retire.
    task automatic run_op(input instr_name_e op, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm,
                          input logic [5:0] tg, input int wait_n,
                          input logic [31:0] rd, input int hold_n);
        logic [31:0] ea, addr, exp_res, exp_w, wmask;
        logic [3:0]  exp_be;
        logic        exp_fault;
        longint      v;
        int          n, lane;
        bit          mem, mis, st, sg;
        ea   = d1 + imm;
        n    = size_of(op);
        lane = int'(ea % 4);
        mem  = (n != 0);
        mis  = mem && (ea % n != 0);
        st   = (op == SB || op == SH || op == SW);
        sg   = (op == LB || op == LH || op == LW);
        addr = ea - lane;
        exp_be = 4'b0;
        exp_w  = 32'b0;
        wmask  = 32'b0;
        exp_fault = 1'b0;
        if (!mem) begin
            exp_res = 32'b0;
        end else if (mis) begin
            exp_res   = ea;
            exp_fault = 1'b1;
        end else begin
            for (int i = lane; i < lane + n; i++) begin
                exp_be[i]       = 1'b1;
                wmask[8*i +: 8] = 8'hFF;
                exp_w[8*i +: 8] = d2[8*(i-lane) +: 8];
            end
            if (st) begin
                exp_res = d2;
            end else begin
                v = (longint'(rd) >> (8*lane)) & ((64'sd1 << (8*n)) - 1);
                if (sg && v >= (64'sd1 << (8*n-1)))
                    v = v - (64'sd1 << (8*n));
                exp_res = v[31:0];
            end
        end

        check("accept_ready", in_ready, 1);
        offer(op, d1, d2, imm, tg);
        @(negedge clk);
        in_valid = 1'b0;
        if (mem && !mis) begin
            for (int c = 0; c <= wait_n; c++) begin
                check("req_held", cif.cache_req, 1);
                check("req_addr", cif.cache_address, addr);
                check("req_we", cif.cache_we, st);
                check("req_be", cif.cache_be, exp_be);
                if (st) check("req_wdata", cif.cache_wdata & wmask, exp_w);
                check("req_no_rv", result_valid, 0);
                check("req_busy", in_ready, 0);
                if (c == wait_n) begin
                    cif.cache_ack   = 1'b1;
                    cif.cache_rdata = rd;
                end
                @(negedge clk);
            end
            cif.cache_ack   = 1'b0;
            cif.cache_rdata = $urandom;
        end
        for (int h = 0; h <= hold_n; h++) begin
            check("done_rv", result_valid, 1);
            check("done_res", result, exp_res);
            check("done_tag", result_tag, tg);
            check("done_fault", fault, exp_fault);
            check("done_busy", in_ready, 0);
            check("done_no_req", cif.cache_req, 0);
            if (h == hold_n) result_ready = 1'b1;
            @(negedge clk);
        end
        result_ready = 1'b0;
        check("retire_rv", result_valid, 0);
        check("retire_ready", in_ready, 1);
    endtask

    initial begin
        instr_name_e ops [9];
        instr_name_e op;
        logic [31:0] r1, r2, rr;
        ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW, ADD};
        reset           = 1'b1;
        in_valid        = 1'b0;
        instr_name      = NOP;
        data_1          = '0;
        data_2          = '0;
        immediate       = '0;
        tag             = '0;
        flush           = 1'b0;
        result_ready    = 1'b0;
        cif.cache_ack   = 1'b0;
        cif.cache_rdata = '0;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        check("reset_not_ready", in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", in_ready, 1);

        // Signed byte load from the top lane.
        run_op(LB, 32'h100, 32'h0, 32'h3, 6'd5, 0, 32'h8000_0000, 0);
        // Halfword store to the upper lane with three wait cycles.
        run_op(SH, 32'h202, 32'h1234_ABCD, 32'h0, 6'd9, 3, 32'h0, 0);
        // Misaligned word load faults without touching the cache.
        run_op(LW, 32'h105, 32'h0, 32'h0, 6'd12, 0, 32'h0, 0);
        // Result held under backpressure.
        run_op(LHU, 32'h300, 32'h0, 32'h2, 6'd33, 1, 32'hF00D_BEEF, 5);
        run_op(ADD, 32'h7, 32'h9, 32'h1, 6'd63, 0, 32'h0, 2);
        run_op(SW, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h8, 6'd1, 0, 32'h0, 0);

        // Ack while idle is ignored.
        cif.cache_ack = 1'b1;
        @(negedge clk);
        cif.cache_ack = 1'b0;
        check("stray_ack_rv", result_valid, 0);
        check("stray_ack_ready", in_ready, 1);

        // Flush and transfer together discard the transfer.
        offer(LW, 32'h400, 32'h0, 32'h0, 6'd7);
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_xfer_req", cif.cache_req, 0);
        check("flush_xfer_rv", result_valid, 0);
        check("flush_xfer_ready", in_ready, 1);

        // Flush one cycle into REQ; request held to ack, no result.
        offer(LW, 32'h500, 32'h0, 32'h4, 6'd20);
        @(negedge clk);
        in_valid = 1'b0;
        check("kill_req_c1", cif.cache_req, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("kill_req_c2", cif.cache_req, 1);
        check("kill_addr", cif.cache_address, 32'h504);
        @(negedge clk);
        check("kill_req_c3", cif.cache_req, 1);
        check("kill_no_rv_c3", result_valid, 0);
        cif.cache_ack   = 1'b1;
        cif.cache_rdata = 32'h1111_2222;
        @(negedge clk);
        cif.cache_ack = 1'b0;
        check("kill_req_drop", cif.cache_req, 0);
        check("kill_no_rv", result_valid, 0);
        check("kill_ready", in_ready, 1);

        // Flush in DONE drops the result.
        offer(LH, 32'h601, 32'h0, 32'h0, 6'd44);
        @(negedge clk);
        in_valid = 1'b0;
        check("flush_done_rv", result_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_clear", result_valid, 0);
        check("flush_done_ready", in_ready, 1);

        // Reset in REQ abandons the request.
        offer(SB, 32'h700, 32'hAB, 32'h1, 6'd50);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_req_on", cif.cache_req, 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("rst_in_req");
        check("rst_in_req_busy", in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", in_ready, 1);
        check("rst_release_req", cif.cache_req, 0);

        // Randomized operations against the model.
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 8)];
            r1 = $urandom & 32'hFFFF_FFF0;
            r2 = $urandom;
            rr = $urandom;
            run_op(op, r1, r2, 32'($urandom_range(0, 15)),
                   6'($urandom_range(0, 63)),
                   $urandom_range(0, 3), rr, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/exu_mem_access.md
EXU_MEM_ACCESS -- requirements
Module: exu_mem_access

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath and address width; legal values 32 and 64.
REQ-002 The block SHALL have parameter TAG_WIDTH, default 6, meaning width of the ROB tag carried with each operation.
REQ-003 The block SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  in  1  operation offered.
REQ-006 The block SHALL have port in_ready  out  1  unit can accept an operation.
REQ-007 The block SHALL have port instr_name  in  instr_name_e  operation (LB, LBU, LH, LHU, LW, SB, SH, SW; others non-memory).
REQ-008 The block SHALL have ports data_1, data_2, immediate  in  XLEN each  base register, store data, offset.
REQ-009 The block SHALL have port tag  in  TAG_WIDTH  ROB tag of offered operation.
REQ-010 The block SHALL have port flush  in  1  kill all accepted, not-yet-completed work.
REQ-011 The block SHALL have ports cache_req, cache_we  out  1 each  request valid, write select.
REQ-012 The block SHALL have ports cache_address, cache_wdata  out  XLEN each  aligned address (low log2(XLEN/8) bits zero), lane-shifted store data.
REQ-013 The block SHALL have port cache_be  out  XLEN/8  byte enables.
REQ-014 The block SHALL have ports cache_ack  in  1, cache_rdata  in  XLEN  request completed; aligned read word valid with ack.
REQ-015 The block SHALL have ports result_valid  out  1, result_ready  in  1  result handshake.
REQ-016 The block SHALL have ports result  out  XLEN, result_tag  out  TAG_WIDTH, fault  out  1  completion data, tag, misalignment flag.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, DONE; in_ready SHALL be 1 only in IDLE with reset low.
REQ-018 Transfer SHALL occur when in_valid && in_ready; the unit SHALL register instr_name, tag, data_2 and ea = data_1 + immediate (mod 2^XLEN).
REQ-019 Misaligned = halfword op with ea[0]=1, or word op with ea[1:0]!=0; a misaligned op SHALL go IDLE->DONE with fault=1, result=ea, no cache request.
REQ-020 A non-memory op SHALL go IDLE->DONE with result=0, fault=0, no cache request.
REQ-021 An aligned memory op SHALL go IDLE->REQ; cache_req SHALL be 1 on the cycle after transfer and held with stable address/we/be/wdata until the cycle cache_ack=1.
REQ-022 An ack seen in REQ SHALL go REQ->DONE the next edge; minimum accept-to-result_valid latency SHALL be 2 cycles; cache_ack outside REQ SHALL be ignored.
REQ-023 Loads SHALL extract byte/halfword/word at lane ea[low bits] from cache_rdata; LB/LH/LW sign-extend, LBU/LHU zero-extend, to XLEN.
REQ-024 Stores SHALL replicate data_2 low bytes into the addressed lane; cache_be SHALL be 1, 2 or 4 contiguous bits from lane ea; result SHALL be data_2.
REQ-025 In DONE, result_valid SHALL be 1 and result/result_tag/fault SHALL be stable; the unit SHALL return to IDLE on the edge where result_ready=1.
REQ-026 Operations SHALL be strictly serial: at most one operation in flight.
REQ-027 flush in IDLE or DONE SHALL force IDLE next cycle with result_valid=0; a flush and a transfer in the same cycle SHALL discard the transfer.
REQ-028 flush in REQ SHALL set a kill flag; cache_req SHALL stay asserted until ack, then the unit SHALL return to IDLE without asserting result_valid.

Reset
REQ-029 While reset=1, next state SHALL be IDLE; kill flag cleared; cache_req, cache_we, cache_be, cache_address, cache_wdata, result_valid, result, result_tag, fault SHALL be 0 the cycle after reset is sampled.
REQ-030 reset SHALL override flush and any in-flight request; a pending ack SHALL not be awaited.

Verification
REQ-031 LB, data_1=0x100, imm=3, ack with rdata=0x80000000 -> cache_address=0x100, be=0b1000, result=0xFFFFFF80, 2-cycle latency.
REQ-032 SH, data_1=0x202, data_2=0x1234ABCD, ack after 3 wait cycles -> address=0x200, be=0b1100, wdata[31:16]=0xABCD, req held 4 cycles, result=0x1234ABCD.
REQ-033 LW, ea=0x105 -> no cache_req, fault=1, result=0x105, result_valid 1 cycle after accept.
REQ-034 result_ready=0 for 5 cycles in DONE -> result/tag/fault stable, in_ready=0 throughout.
REQ-035 flush 1 cycle into REQ, ack 2 cycles later -> req held until ack, no result_valid, in_ready=1 next cycle.
REQ-036 reset asserted in REQ -> next cycle cache_req=0, all outputs 0, in_ready=1 after reset drops.
